// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
package serial_sub_pkg;

    // Controller state encodings (2-bit, legacy-compatible constants)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // True in the states where a start request may be accepted
    function automatic logic can_accept(logic [1:0] st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational one-bit full subtractor: X - Y - Bin -> D, Bout.
module fs_cell (
    input  logic X,
    input  logic Y,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    // Difference bit and borrow-out of a single bit position
    assign D    = X ^ Y ^ Bin;
    assign Bout = (~X & Y) | (~(X ^ Y) & Bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin LSB-first through a single
// full-subtractor cell, one bit per clock, with a start/busy/done handshake.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             brw;
    logic [CNT_W-1:0] cnt;
    logic             cell_d;
    logic             cell_bout;
    logic             accept;

    // The single shared cell always looks at the current LSBs and borrow
    fs_cell u_cell (
        .X    (sa[0]),
        .Y    (sb[0]),
        .Bin  (brw),
        .D    (cell_d),
        .Bout (cell_bout)
    );

    assign accept = start && can_accept(state);
    assign busy   = (state == ST_SHIFT);
    assign done   = (state == ST_DONE);

    // FSM, operand shift registers, borrow chain and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    // Result bits enter at the MSB so the LSB lands in bit 0 last
                    diff <= {cell_d, diff[WIDTH-1:1]};
                    brw  <= cell_bout;
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    if (cnt == CNT_LAST) begin
                        bout  <= cell_bout;
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    // DONE accepts start exactly like IDLE for back-to-back ops
                    if (accept) begin
                        sa    <= a;
                        sb    <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        diff  <= '0;
                        bout  <= 1'b0;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8 and WIDTH=3 instances).
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;

    logic       start3, bin3, busy3, done3, bout3;
    logic [2:0] a3, b3, diff3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub_ctrl #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
    );

    // Reference: plain modular arithmetic and an unsigned compare
    function automatic int unsigned ref_diff(int unsigned x, int unsigned y,
                                             int unsigned c, int w);
        return (x - y - c) & ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic ref_bout(int unsigned x, int unsigned y, int unsigned c);
        return (x < y + c);
    endfunction

    // Launch one 8-bit op from a point #1 after an edge; returns when done seen
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        output int lat, output int nbusy);
        a8 = ta; b8 = tb_v; bin8 = tc; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1; nbusy = 0;
        while (!done8 && lat < 40) begin
            if (busy8) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run3(input logic [2:0] ta, input logic [2:0] tb_v, input logic tc,
                        output int lat);
        a3 = ta; b3 = tb_v; bin3 = tc; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat = 1;
        while (!done3 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy8); end
        n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done8); end
        n_cmp++; if (diff8 !== 8'h00) begin n_bad++; $display("FAIL reset_diff got %h want 00", diff8); end
        n_cmp++; if (bout8 !== 1'b0) begin n_bad++; $display("FAIL reset_bout got %b want 0", bout8); end
        n_cmp++; if (busy3 !== 1'b0 || done3 !== 1'b0 || diff3 !== 3'd0 || bout3 !== 1'b0) begin
            n_bad++; $display("FAIL reset_w3 got %b%b%h%b want 0000", busy3, done3, diff3, bout3);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, nb;
        logic [7:0] held;
        run8(8'h5A, 8'h3C, 1'b0, lat, nb);
        n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL basic_latency got %0d want 9", lat); end
        n_cmp++; if (nb != 8) begin n_bad++; $display("FAIL basic_busy_cycles got %0d want 8", nb); end
        n_cmp++; if (diff8 !== 8'h1E) begin n_bad++; $display("FAIL basic_diff got %h want 1e", diff8); end
        n_cmp++; if (bout8 !== 1'b0) begin n_bad++; $display("FAIL basic_bout got %b want 0", bout8); end
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy8); end
        held = diff8;
        // Result must hold while idle; done must drop after one cycle
        @(posedge clk); #1;
        n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", done8); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (diff8 !== held || bout8 !== 1'b0) begin
            n_bad++; $display("FAIL basic_hold got %h/%b want %h/0", diff8, bout8, held);
        end
    endtask

    task automatic test_borrow();
        int lat, nb;
        run8(8'h00, 8'h01, 1'b0, lat, nb);
        n_cmp++; if (diff8 !== 8'hFF || bout8 !== 1'b1) begin
            n_bad++; $display("FAIL borrow_0m1 got %h/%b want ff/1", diff8, bout8);
        end
        run8(8'h10, 8'h10, 1'b1, lat, nb);
        n_cmp++; if (diff8 !== 8'hFF || bout8 !== 1'b1) begin
            n_bad++; $display("FAIL borrow_eq_bin got %h/%b want ff/1", diff8, bout8);
        end
        run8(8'h00, 8'hFF, 1'b1, lat, nb);
        n_cmp++; if (diff8 !== 8'h00 || bout8 !== 1'b1) begin
            n_bad++; $display("FAIL borrow_0_ff_bin got %h/%b want 00/1", diff8, bout8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL b2b_lat1 got %0d want 9", lat); end
        n_cmp++; if (diff8 !== 8'h02 || bout8 !== 1'b0) begin
            n_bad++; $display("FAIL b2b_res1 got %h/%b want 02/0", diff8, bout8);
        end
        a8 = 8'h03; b8 = 8'h05;
        @(posedge clk); #1;
        n_cmp++; if (busy8 !== 1'b1 || diff8 !== 8'h00) begin
            n_bad++; $display("FAIL b2b_accept got busy=%b diff=%h want busy=1 diff=00", busy8, diff8);
        end
        lat = 1;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        start8 = 1'b0;
        n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL b2b_lat2 got %0d want 9", lat); end
        n_cmp++; if (diff8 !== 8'hFE || bout8 !== 1'b1) begin
            n_bad++; $display("FAIL b2b_res2 got %h/%b want fe/1", diff8, bout8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        a8 = 8'hC3; b8 = 8'h4D; bin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        if (done8) ndone++;
        repeat (2) begin @(posedge clk); #1; if (done8) ndone++; end
        // busy cycle 3: new request with different operands
        a8 = 8'h11; b8 = 8'h99; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        if (done8) ndone++;
        for (int i = 0; i < 12; i++) begin
            if (done8) begin
                n_cmp++;
                if (diff8 !== 8'(ref_diff(32'hC3, 32'h4D, 1, 8)) || bout8 !== ref_bout(32'hC3, 32'h4D, 1)) begin
                    n_bad++; $display("FAIL ignore_result got %h/%b want 75/0", diff8, bout8);
                end
            end
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        int lat, nb;
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy8); end
        n_cmp++; if (diff8 !== 8'h00 || bout8 !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_result got %h/%b want 00/0", diff8, bout8);
        end
        for (int i = 0; i < 12; i++) begin
            if (done8) ndone++;
            @(posedge clk); #1;
        end
        n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d want 0", ndone); end
        run8(8'h37, 8'hA2, 1'b1, lat, nb);
        n_cmp++; if (lat != 9 || diff8 !== 8'(ref_diff(32'h37, 32'hA2, 1, 8)) || bout8 !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_fresh got lat=%0d %h/%b want lat=9 %h/1",
                              lat, diff8, bout8, 8'(ref_diff(32'h37, 32'hA2, 1, 8)));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive_w3();
        int lat;
        logic [6:0] v;
        for (int i = 0; i < 128; i++) begin
            v = 7'(i);
            run3(v[6:4], v[3:1], v[0], lat);
            n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL w3_lat case %0d got %0d want 4", i, lat); end
            n_cmp++; if (diff3 !== 3'(ref_diff(32'(v[6:4]), 32'(v[3:1]), 32'(v[0]), 3))) begin
                n_bad++; $display("FAIL w3_diff case %0d got %h want %h", i, diff3,
                                  3'(ref_diff(32'(v[6:4]), 32'(v[3:1]), 32'(v[0]), 3)));
            end
            n_cmp++; if (bout3 !== ref_bout(32'(v[6:4]), 32'(v[3:1]), 32'(v[0]))) begin
                n_bad++; $display("FAIL w3_bout case %0d got %b want %b", i, bout3,
                                  ref_bout(32'(v[6:4]), 32'(v[3:1]), 32'(v[0])));
            end
        end
    endtask

    task automatic test_random();
        int lat, nb;
        logic [7:0] ra, rb;
        logic rc;
        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            run8(ra, rb, rc, lat, nb);
            n_cmp++;
            if (lat != 9 || diff8 !== 8'(ref_diff(32'(ra), 32'(rb), 32'(rc), 8)) ||
                bout8 !== ref_bout(32'(ra), 32'(rb), 32'(rc))) begin
                n_bad++; $display("FAIL rand %h-%h-%b got lat=%0d %h/%b want lat=9 %h/%b",
                                  ra, rb, rc, lat, diff8, bout8,
                                  8'(ref_diff(32'(ra), 32'(rb), 32'(rc), 8)),
                                  ref_bout(32'(ra), 32'(rb), 32'(rc)));
            end
            // Randomly mix back-to-back starts with idle gaps
            if ($urandom_range(1, 0) == 1) begin
                repeat ($urandom_range(3, 1)) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_exhaustive_w3();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
